debounce_filter_mc: RTL and testbench

- Multi-channel, parametrised glitch/debounce filter for slow external inputs such as buttons, switches and limit sensors.
- Each channel has its own 2-flop synchroniser and a consecutive-sample counter.
- A channel output changes only after the input has held the opposite level for a runtime-programmable number of sample ticks.
- A shared prescaler sets the sample rate; each channel also produces one-cycle rise/fall event pulses for downstream control FSMs.

---
 rtl/debounce_filter_mc.sv | 78 +++++++
 tb/tb_debounce_filter_mc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_filter_mc.sv
// Multi-channel debounce filter: per-channel 2-flop synchroniser and stability
// counter, shared sample-tick prescaler, registered rise/fall event pulses.
module debounce_filter_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CNT_W-1:0]    thresh,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [PS_W-1:0]     ps;
  logic                tick;
  logic [CNT_W:0]      teff;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps <= '0;
    end else if (enable) begin
      if (ps == PS_LAST) ps <= '0;
      else               ps <= ps + PS_W'(1);
    end
  end

  assign tick = enable && (ps == PS_LAST);
  assign teff = (thresh == '0) ? ONE_W : {1'b0, thresh};

  // Count is widened by one bit before the compare so it can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_out <= '0;
      rise    <= '0;
      fall    <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      if (tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (s2[i] == sig_out[i]) begin
            cnt[i] <= '0;
          end else if (({1'b0, cnt[i]} + ONE_W) >= teff) begin
            sig_out[i] <= s2[i];
            cnt[i]     <= '0;
            rise[i]    <= s2[i];
            fall[i]    <= ~s2[i];
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_filter_mc.sv
// Directed bench for debounce_filter_mc: one instance with PRESCALE=1 and one
// with PRESCALE=4 sharing clock and reset.
module tb_debounce_filter_mc;

  logic       clock;
  logic       reset;
  logic       enable_a, enable_b;
  logic [3:0] thresh_a, thresh_b;
  logic [3:0] sig_in_a, sig_in_b;
  logic [3:0] sig_out_a, rise_a, fall_a;
  logic [3:0] sig_out_b, rise_b, fall_b;
  logic [3:0] acc_rise, acc_fall;
  int checks;
  int fails;

  debounce_filter_mc #(.CHANNELS(4), .CNT_W(4), .PRESCALE(1), .PS_W(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable_a), .thresh(thresh_a),
    .sig_in(sig_in_a), .sig_out(sig_out_a), .rise(rise_a), .fall(fall_a)
  );

  debounce_filter_mc #(.CHANNELS(4), .CNT_W(4), .PRESCALE(4), .PS_W(8)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b), .thresh(thresh_b),
    .sig_in(sig_in_b), .sig_out(sig_out_b), .rise(rise_b), .fall(fall_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Waits n rising edges, sampling 1 ns after each, and accumulates A's pulses.
  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      acc_rise |= rise_a;
      acc_fall |= fall_a;
    end
  endtask

  initial begin
    checks = 0; fails = 0;
    acc_rise = '0; acc_fall = '0;
    reset = 1'b1;
    enable_a = 1'b1; enable_b = 1'b0;
    thresh_a = 4'd3; thresh_b = 4'd2;
    sig_in_a = 4'h0; sig_in_b = 4'h0;
    #3;
    chk("reset_out", {20'd0, sig_out_a, rise_a, fall_a}, 32'd0);
    clk_wait(2);
    chk("reset_hold", {20'd0, sig_out_b, rise_b, fall_b}, 32'd0);
    reset = 1'b0;

    // Step response, thresh=3: toggle at edge 4
    sig_in_a = 4'b0001;
    acc_rise = '0; acc_fall = '0;
    clk_wait(4);
    chk("step_before", sig_out_a, 4'b0000);
    clk_wait(1);
    chk("step_out", sig_out_a, 4'b0001);
    chk("step_rise", rise_a, 4'b0001);
    clk_wait(1);
    chk("step_rise_one", rise_a, 4'b0000);
    chk("step_no_fall", acc_fall, 4'b0000);

    // 2-clock glitch on ch1 rejected
    acc_rise = '0; acc_fall = '0;
    sig_in_a = 4'b0011;
    clk_wait(2);
    sig_in_a = 4'b0001;
    clk_wait(6);
    chk("glitch2_out", sig_out_a, 4'b0001);
    chk("glitch2_rise", acc_rise, 4'b0000);

    // 3-clock pulse passes, then falls 3 ticks after input drops
    acc_rise = '0; acc_fall = '0;
    sig_in_a = 4'b0011;
    clk_wait(3);
    sig_in_a = 4'b0001;
    clk_wait(1);
    chk("pulse3_before", sig_out_a, 4'b0001);
    clk_wait(1);
    chk("pulse3_out", sig_out_a, 4'b0011);
    chk("pulse3_rise", rise_a, 4'b0010);
    clk_wait(2);
    chk("pulse3_hold", sig_out_a, 4'b0011);
    acc_fall = '0;
    clk_wait(1);
    chk("pulse3_back", sig_out_a, 4'b0001);
    chk("pulse3_fall", fall_a, 4'b0010);
    clk_wait(1);
    chk("pulse3_fall_one", fall_a, 4'b0000);

    // thresh=0 behaves as 1: toggle at edge 2
    thresh_a = 4'd0;
    sig_in_a = 4'b0000;
    clk_wait(2);
    chk("th0_before", sig_out_a, 4'b0001);
    clk_wait(1);
    chk("th0_out", sig_out_a, 4'b0000);
    chk("th0_fall", fall_a, 4'b0001);

    // Shrink thresh 8 -> 2 with count at 5
    thresh_a = 4'd8;
    sig_in_a = 4'b0001;
    clk_wait(7);
    chk("shrink_before", sig_out_a, 4'b0000);
    thresh_a = 4'd2;
    clk_wait(1);
    chk("shrink_out", sig_out_a, 4'b0001);
    chk("shrink_rise", rise_a, 4'b0001);

    // Multi-channel simultaneous toggle, thresh=1
    thresh_a = 4'd1;
    sig_in_a = 4'b0000;
    clk_wait(4);
    chk("multi_clear", sig_out_a, 4'b0000);
    sig_in_a = 4'b1111;
    clk_wait(2);
    chk("multi_before", sig_out_a, 4'b0000);
    clk_wait(1);
    chk("multi_out", sig_out_a, 4'b1111);
    chk("multi_rise", rise_a, 4'b1111);
    clk_wait(1);
    chk("multi_rise_one", rise_a, 4'b0000);

    // ch1 drops for good while ch2 glitches for 2 clocks, thresh=3
    thresh_a = 4'd3;
    acc_fall = '0;
    sig_in_a = 4'b1001;
    clk_wait(2);
    sig_in_a = 4'b1101;
    clk_wait(3);
    chk("neigh_out", sig_out_a, 4'b1101);
    chk("neigh_fall", fall_a, 4'b0010);
    acc_fall = '0;
    clk_wait(6);
    chk("neigh_hold", sig_out_a, 4'b1101);
    chk("neigh_no_fall", acc_fall, 4'b0000);

    // Prescaler=4, thresh=2: ticks at edges 3,7 -> toggle at edge 7
    enable_b = 1'b1;
    sig_in_b = 4'b0100;
    clk_wait(7);
    chk("ps_before", sig_out_b, 4'b0000);
    clk_wait(1);
    chk("ps_out", sig_out_b, 4'b0100);
    chk("ps_rise", rise_b, 4'b0100);

    // Enable dropped 10 clocks after edge 4: toggle moves from edge 7 to 17
    sig_in_b = 4'b0000;
    clk_wait(5);
    enable_b = 1'b0;
    clk_wait(10);
    chk("en_frozen", sig_out_b, 4'b0100);
    enable_b = 1'b1;
    clk_wait(2);
    chk("en_before", sig_out_b, 4'b0100);
    clk_wait(1);
    chk("en_out", sig_out_b, 4'b0000);
    chk("en_fall", fall_b, 4'b0100);

    // Async reset mid-cycle with counts in progress
    thresh_a = 4'd8;
    sig_in_a = 4'b0000;
    clk_wait(3);
    #2;
    reset = 1'b1;
    sig_in_a = 4'b1111;
    #1;
    chk("arst_out", sig_out_a, 4'b0000);
    chk("arst_pulse", {rise_a, fall_a}, 8'h00);
    clk_wait(2);
    chk("arst_hold", sig_out_a, 4'b0000);
    reset = 1'b0;
    clk_wait(9);
    chk("arst_release_hold", sig_out_a, 4'b0000);
    clk_wait(1);
    chk("arst_release_out", sig_out_a, 4'b1111);
    chk("arst_release_rise", rise_a, 4'b1111);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
